uart_transmitter: RTL
=====================

# uart_transmitter

Serial UART transmitter. Accepts one byte per valid/ready handshake and drives an idle-high line with a frame of start bit, 8 data bits LSB first, even parity bit and one stop bit. Counterpart of the team's even-parity 8-bit UART receiver: one receiver and one transmitter share a `CLKS_PER_BIT` setting to form a full link between chips.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled only on handshake.
- `tx_valid`  input  1  producer has a byte on `tx_data`.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `tx_out`  output  1  serial line; idle level 1.
- `tx_busy`  output  1  a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_ready`=1, `tx_busy`=0, `tx_out`=1.
  - On `tx_valid && tx_ready` at a rising edge:
    - latch `tx_data` into the shift register;
    - latch parity = XOR of the 8 bits, so total ones across data+parity is even;
    - clear the baud counter and bit index; go to START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - `tx_out` = shift register bit 0; shift right once per bit period.
  - 3-bit bit index counts 0..7; after bit 7's period, go to PARITY.
- PARITY: `tx_out` = latched parity bit for one bit period, then STOP.
- STOP: `tx_out`=1 for one bit period, then IDLE.
- `tx_busy`=1 and `tx_ready`=0 in every state except IDLE.
- `tx_valid` outside IDLE is ignored. No byte is queued, and the producer must hold it.
- Changes to `tx_data` after the handshake do not affect the frame in flight.
- Baud counter:
  - width `$clog2(CLKS_PER_BIT)`; counts 0..`CLKS_PER_BIT`-1 and wraps to 0.
  - State/bit advance occurs on the cycle the counter equals `CLKS_PER_BIT`-1.
- `tx_out` is driven from a flop, never combinationally from the FSM.

## Timing
- Reset values: `tx_out`=1, `tx_ready`=1, `tx_busy`=0; FSM=IDLE; counter, bit index and shift register = 0.
- Reset is asynchronous. Assertion mid-frame forces `tx_out`=1 immediately and abandons the frame; no partial byte resumes.
- Handshake at edge N:
  - `tx_ready` falls and `tx_out` goes 0 (start bit) after edge N;
  - start bit occupies cycles N+1..N+`CLKS_PER_BIT`.
- Frame length: 11×`CLKS_PER_BIT` cycles (parity on), 10×`CLKS_PER_BIT` cycles (parity off).
- After STOP, one IDLE cycle with `tx_ready`=1 is mandatory. With `tx_valid` held high, the next start bit begins 11×`CLKS_PER_BIT`+1 cycles after the previous one.
- Simultaneous reset and handshake: reset wins; the byte is dropped.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: PARITY state present; 11-bit frame with even parity.
- Undefined: PARITY state and parity flop compiled out; DATA goes directly to STOP; 10-bit frame.
- The receiver side must be built with the matching setting.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_tx_state_t`;
  - constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1, `UART_START_LEVEL`=1'b0, `UART_STOP_LEVEL`=1'b1.
  - The receiver reuses the same constants.
- Sub-module `uart_baud_gen`: parameterised by `CLKS_PER_BIT`; inputs `clk`, `reset`, `clear`; output one-cycle `bit_tick` on the counter wrap. The receiver can reuse it.

## Test plan
- `CLKS_PER_BIT`=4, send 0xA5 → after reset idle 1, line reads 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit held exactly 4 cycles; `tx_busy` high 44 cycles.
- Send 0x07 → data bits 1,1,1,0,0,0,0,0, parity 1; send 0x00 → parity 0.
- `tx_valid` held high with 0x3C then 0xC3 → two complete frames; second start bit exactly 45 cycles after the first; exactly one idle cycle between frames.
- Pulse `tx_valid` with 0xFF while `tx_busy`=1 → ignored; in-flight frame unchanged; no second frame.
- Assert `reset` mid-DATA at bit 3 → `tx_out`=1 within the same cycle; `tx_ready`=1 and `tx_busy`=0; next byte 0x55 transmits correctly.
- Build without `UART_TX_PARITY_EN`, send 0xA5 → stop bit immediately follows data bit 7; frame 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// parity helper. Used by the transmitter and reusable by the receiver.
// Build option: `UART_TX_PARITY_EN adds the even-parity state to the frame.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity: result makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and pulses bit_tick for one
// cycle while the counter sits at its last value. 'clear' holds it at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero when cleared, otherwise wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == CNT_MAX) && !clear;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, framed as start bit,
// 8 data bits LSB first, optional even parity bit, one stop bit.
// Build option: define UART_TX_PARITY_EN for the 11-bit frame with parity;
// leave it undefined for the 10-bit frame (data goes straight to stop).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_out,
  output logic                      tx_busy
);

  uart_tx_state_t            state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_idx_q;
  logic                      tx_out_q;
  logic                      ready_q;
  logic                      busy_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  logic baud_clear_s;
  logic bit_tick_s;

  // The bit timer only runs while a frame is in flight, so every frame
  // starts with a full-length start bit.
  assign baud_clear_s = (state_q == TX_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear_s),
    .bit_tick(bit_tick_s)
  );

  // Frame sequencer; line level and handshake outputs are registered here
  // from the next state so tx_out never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= {UART_DATA_BITS{1'b0}};
      bit_idx_q <= 3'd0;
      tx_out_q  <= UART_IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (tx_valid && ready_q) begin
            shift_q   <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= even_parity(tx_data);
`endif
            bit_idx_q <= 3'd0;
            state_q   <= TX_START;
            tx_out_q  <= UART_START_LEVEL;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            tx_out_q  <= UART_IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_tick_s) begin
            state_q  <= TX_DATA;
            tx_out_q <= shift_q[0];
          end
        end
        TX_DATA: begin
          if (bit_tick_s) begin
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= TX_PARITY;
              tx_out_q <= parity_q;
`else
              state_q  <= TX_STOP;
              tx_out_q <= UART_STOP_LEVEL;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              tx_out_q  <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_tick_s) begin
            state_q  <= TX_STOP;
            tx_out_q <= UART_STOP_LEVEL;
          end
        end
`endif
        TX_STOP: begin
          if (bit_tick_s) begin
            state_q  <= TX_IDLE;
            tx_out_q <= UART_IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= TX_IDLE;
          tx_out_q <= UART_IDLE_LEVEL;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;

endmodule
